// File: rtl/imem_arbiter.sv
// Shares the single-port instruction BRAM between CPU fetch and the program loader.
// Loader wins by default; fetch gets a forced slot after MAX_LD_STREAK loader wins.
module imem_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int RD_LAT        = 1,
  parameter int MAX_LD_STREAK = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W+1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_rerr,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              cpu_stall,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LD_STREAK);

  logic              rst_done;
  logic [3:0]        streak;
  logic              fetch_force;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_own_f;
  logic [RD_LAT-1:0] pipe_mis;

  always_comb begin
    fetch_force = fetch_req & ~ld_lock & (streak == STREAK_MAX);
    ld_gnt      = rst_done & ld_req & ~fetch_force;
    fetch_gnt   = rst_done & fetch_req & ~ld_lock & (~ld_req | fetch_force);
    cpu_stall   = rst_done & (ld_lock | (fetch_req & ~fetch_gnt));
    bram_en     = fetch_gnt | ld_gnt;
    bram_we     = ld_gnt & ld_we;
    bram_addr   = addr_q;
    if (fetch_gnt)
      bram_addr = fetch_addr[ADDR_W+1:2];
    else if (ld_gnt)
      bram_addr = ld_addr;
    bram_din    = ld_gnt ? ld_wdata : din_q;
  end

  // Return pipeline tags each read with its owner so data can be steered back.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_done   <= 1'b0;
      streak     <= 4'd0;
      addr_q     <= '0;
      din_q      <= '0;
      pipe_v     <= '0;
      pipe_own_f <= '0;
      pipe_mis   <= '0;
    end else begin
      rst_done <= 1'b1;
      if (ld_lock | ~fetch_req | fetch_gnt)
        streak <= 4'd0;
      else if (ld_gnt)
        streak <= streak + 4'd1;
      if (bram_en)
        addr_q <= bram_addr;
      if (ld_gnt)
        din_q <= ld_wdata;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]     <= pipe_v[i-1];
        pipe_own_f[i] <= pipe_own_f[i-1];
        pipe_mis[i]   <= pipe_mis[i-1];
      end
      pipe_v[0]     <= fetch_gnt | (ld_gnt & ~ld_we);
      pipe_own_f[0] <= fetch_gnt;
      pipe_mis[0]   <= fetch_gnt & (fetch_addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    fetch_rvalid = pipe_v[RD_LAT-1] & pipe_own_f[RD_LAT-1];
    ld_rvalid    = pipe_v[RD_LAT-1] & ~pipe_own_f[RD_LAT-1];
    fetch_rerr   = pipe_v[RD_LAT-1] & pipe_own_f[RD_LAT-1] & pipe_mis[RD_LAT-1];
    fetch_rdata  = bram_dout;
    ld_rdata     = bram_dout;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share stimulus,
// each with its own BRAM model; a rule-level reference decides grants and expected returns.
module tb_imem_arbiter;
  localparam int AW   = 12;
  localparam int MAXS = 4;

  typedef struct {
    bit          is_f;
    logic [31:0] data;
    bit          err;
    int          due;
  } item_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          fetch_req, ld_req, ld_we, ld_lock;
  logic [AW+1:0] fetch_addr;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;

  logic          f1_gnt, f1_rv, f1_err, l1_gnt, l1_rv, st1, en1, we1;
  logic [31:0]   f1_rd, l1_rd, din1, dout1;
  logic [AW-1:0] addr1;
  logic          f3_gnt, f3_rv, f3_err, l3_gnt, l3_rv, st3, en3, we3;
  logic [31:0]   f3_rd, l3_rd, din3, dout3;
  logic [AW-1:0] addr3;

  imem_arbiter #(.ADDR_W(AW), .RD_LAT(1), .MAX_LD_STREAK(MAXS)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(f1_gnt),
    .fetch_rvalid(f1_rv), .fetch_rdata(f1_rd), .fetch_rerr(f1_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_lock(ld_lock), .ld_gnt(l1_gnt), .ld_rvalid(l1_rv), .ld_rdata(l1_rd),
    .cpu_stall(st1), .bram_en(en1), .bram_we(we1), .bram_addr(addr1),
    .bram_din(din1), .bram_dout(dout1));

  imem_arbiter #(.ADDR_W(AW), .RD_LAT(3), .MAX_LD_STREAK(MAXS)) dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(f3_gnt),
    .fetch_rvalid(f3_rv), .fetch_rdata(f3_rd), .fetch_rerr(f3_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_lock(ld_lock), .ld_gnt(l3_gnt), .ld_rvalid(l3_rv), .ld_rdata(l3_rd),
    .cpu_stall(st3), .bram_en(en3), .bram_we(we3), .bram_addr(addr3),
    .bram_din(din3), .bram_dout(dout3));

  logic [31:0] mem1 [4096];
  logic [31:0] mem3 [4096];
  logic [31:0] mmem [4096];
  logic [31:0] r0, r1;

  function automatic logic [31:0] init_word(input int i);
    return {16'hC0DE ^ 16'(i), 16'(i)};
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = init_word(i);
      mem3[i] = init_word(i);
      mmem[i] = init_word(i);
    end
  end

  always @(posedge sys_clk) begin
    if (en1 && we1) mem1[addr1] <= din1;
    dout1 <= mem1[addr1];
  end

  always @(posedge sys_clk) begin
    if (en3 && we3) mem3[addr3] <= din3;
    r0    <= mem3[addr3];
    r1    <= r0;
    dout3 <= r1;
  end

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  item_t q1[$];
  item_t q3[$];
  int    m_streak = 0;
  bit    m_rdone;
  logic [AW-1:0] m_last_addr = '0;
  bit    f_taken = 1'b0;
  bit    l_taken = 1'b0;

  always @(posedge sys_clk) cyc++;

  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) m_rdone <= 1'b0;
    else            m_rdone <= 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  task automatic chk_dut(input string nm, input logic fg, input logic lg, input logic st,
                         input logic en, input logic we, input logic [AW-1:0] ad,
                         input logic [31:0] dn, input bit ef, input bit el, input bit es,
                         input logic [AW-1:0] ea);
    chk({nm, " gnt"}, 32'({fg, lg}), 32'({ef, el}));
    chk({nm, " stall"}, 32'(st), 32'(es));
    chk({nm, " bram_en"}, 32'(en), 32'(ef | el));
    chk({nm, " bram_we"}, 32'(we), 32'(el & ld_we));
    chk({nm, " bram_addr"}, 32'(ad), 32'(ea));
    if (el && ld_we) chk({nm, " bram_din"}, dn, ld_wdata);
  endtask

  // Reference: decide the owner of the BRAM this cycle from the arbitration rules.
  always @(negedge sys_clk) begin
    bit ef, el, es;
    logic [AW-1:0] ea;
    item_t it;
    f_taken = f1_gnt;
    l_taken = l1_gnt;
    if (!sys_rst_n) begin
      chk("reset outs lat1", 32'({f1_gnt, l1_gnt, f1_rv, l1_rv, f1_err, en1, we1, st1}), 32'd0);
      chk("reset outs lat3", 32'({f3_gnt, l3_gnt, f3_rv, l3_rv, f3_err, en3, we3, st3}), 32'd0);
      q1.delete();
      q3.delete();
      m_streak    = 0;
      m_last_addr = '0;
    end else begin
      ef = 1'b0;
      el = 1'b0;
      if (m_rdone) begin
        if (fetch_req && !ld_lock && (!ld_req || m_streak == MAXS)) ef = 1'b1;
        else if (ld_req) el = 1'b1;
      end
      es = m_rdone && (ld_lock || (fetch_req && !ef));
      ea = ef ? fetch_addr[AW+1:2] : (el ? ld_addr : m_last_addr);
      chk_dut("lat1", f1_gnt, l1_gnt, st1, en1, we1, addr1, din1, ef, el, es, ea);
      chk_dut("lat3", f3_gnt, l3_gnt, st3, en3, we3, addr3, din3, ef, el, es, ea);
      if (ef || (el && !ld_we)) begin
        it.is_f = ef;
        it.data = mmem[ea];
        it.err  = ef && (fetch_addr[1:0] != 2'b00);
        it.due  = cyc + 1;
        q1.push_back(it);
        it.due  = cyc + 3;
        q3.push_back(it);
      end
      if (el && ld_we) mmem[ea] = ld_wdata;
      if (ef || el) m_last_addr = ea;
      m_streak = (el && fetch_req && !ld_lock) ? m_streak + 1 : 0;
    end
  end

  task automatic mon(input int k, input logic frv, input logic lrv, input logic [31:0] frd,
                     input logic [31:0] lrd, input logic ferr);
    item_t it;
    bit    have;
    string nm;
    nm = (k == 0) ? "lat1" : "lat3";
    for (int n = 0; n < 8; n++) begin
      have = (k == 0) ? (q1.size() > 0) : (q3.size() > 0);
      if (!have) break;
      it = (k == 0) ? q1[0] : q3[0];
      if (it.due >= cyc) break;
      checks++;
      failures++;
      $display("FAIL %s missing return cyc=%0d actual=none required=due %0d", nm, cyc, it.due);
      if (k == 0) void'(q1.pop_front()); else void'(q3.pop_front());
    end
    have = (k == 0) ? (q1.size() > 0) : (q3.size() > 0);
    if (have) it = (k == 0) ? q1[0] : q3[0];
    if (frv || lrv) begin
      checks++;
      if (!have || it.due != cyc) begin
        failures++;
        $display("FAIL %s unexpected rvalid cyc=%0d actual=%b%b required=none", nm, cyc, frv, lrv);
      end else begin
        chk({nm, " owner"}, 32'({frv, lrv}), 32'({it.is_f, !it.is_f}));
        chk({nm, " rdata"}, it.is_f ? frd : lrd, it.data);
        chk({nm, " rerr"}, 32'(ferr), 32'(it.err));
        if (k == 0) void'(q1.pop_front()); else void'(q3.pop_front());
      end
    end else begin
      if (have && it.due == cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missing return cyc=%0d actual=none required=due %0d", nm, cyc, it.due);
        if (k == 0) void'(q1.pop_front()); else void'(q3.pop_front());
      end
      chk({nm, " rerr idle"}, 32'(ferr), 32'd0);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      mon(0, f1_rv, l1_rv, f1_rd, l1_rd, f1_err);
      mon(1, f3_rv, l3_rv, f3_rd, l3_rd, f3_err);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_f(input string nm);
    int t;
    for (t = 0; t < 50; t++) begin
      tick();
      if (f_taken) break;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL %s fetch grant timeout actual=none required=grant", nm);
    end
    fetch_req = 1'b0;
  endtask

  task automatic wait_l(input string nm);
    int t;
    for (t = 0; t < 50; t++) begin
      tick();
      if (l_taken) break;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL %s loader grant timeout actual=none required=grant", nm);
    end
    ld_req = 1'b0;
  endtask

  task automatic step(input int pf, input int pl, input int plock, input int pwe);
    if (!fetch_req || f_taken) begin
      fetch_req  = ($urandom_range(99) < pf);
      fetch_addr = {12'($urandom), ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00};
    end
    if (!ld_req || l_taken) begin
      ld_req   = ($urandom_range(99) < pl);
      ld_we    = ($urandom_range(99) < pwe);
      ld_addr  = 12'($urandom);
      ld_wdata = $urandom;
    end
    ld_lock = ($urandom_range(99) < plock);
    tick();
  endtask

  initial begin
    int nf;
    fetch_req  = 1'b1;
    fetch_addr = '0;
    ld_req     = 1'b0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;
    ld_lock    = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    wait_f("boot fetch");

    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'd5; ld_wdata = 32'hDEADBEEF;
    wait_l("ld write");
    fetch_req = 1'b1; fetch_addr = 14'h14;
    wait_f("fetch 0x14");

    fetch_req = 1'b1; fetch_addr = 14'h100;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'h20;
    nf = 0;
    for (int i = 0; i < 25; i++) begin
      step(100, 100, 0, 0);
      if (f_taken) nf++;
    end
    chk("streak fetch share", 32'(nf), 32'd5);
    fetch_req = 1'b0; ld_req = 1'b0;
    tick();
    tick();

    ld_lock = 1'b1; fetch_req = 1'b1; fetch_addr = 14'h40;
    repeat (10) tick();
    ld_lock = 1'b0;
    tick();
    chk("fetch after unlock", 32'(f_taken), 32'd1);
    fetch_req = 1'b0;
    tick();

    fetch_req = 1'b1; fetch_addr = 14'h6;
    wait_f("misaligned");
    repeat (5) tick();

    repeat (400) step(60, 50, 10, 40);
    fetch_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
    repeat (6) tick();

    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'd3;
    tick();
    ld_addr = 12'd4;
    tick();
    sys_rst_n = 1'b0;
    ld_req = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
